miriscv_lsu: RTL and testbench
==============================

Name: miriscv_lsu

Overview:
Load/store unit on the memory side of the execute stage. It consumes the decoder's memory controls (request, write enable, funct3 size), address and store data. It runs a req/gnt/rvalid transaction on the data-memory port, aligns byte lanes, sign- or zero-extends load data, and stalls the pipeline until the access completes.

Parameters:
XLEN, 32, data/address width; only 32 is supported.

Ports:
clk_i  in  1  core clock
rst_i  in  1  synchronous active-high reset
lsu_req_i  in  1  memory instruction in EX; held high while lsu_stall_req_o=1
lsu_we_i  in  1  1=store, 0=load
lsu_size_i  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
lsu_addr_i  in  XLEN  byte address
lsu_data_i  in  XLEN  store data, rs2
lsu_kill_i  in  1  pipeline flush
lsu_stall_req_o  out  1  hold pipeline
lsu_valid_o  out  1  one-cycle completion pulse
lsu_misaligned_o  out  1  misaligned-access flag, valid with lsu_valid_o
lsu_data_o  out  XLEN  extended load result, valid with lsu_valid_o
data_req_o  out  1  memory request
data_we_o  out  1  memory write
data_be_o  out  4  byte enables
data_addr_o  out  XLEN  word address, bits[1:0]=0
data_wdata_o  out  XLEN  lane-replicated store data
data_gnt_i  in  1  request accepted
data_rvalid_i  in  1  response valid, for loads and stores
data_rdata_i  in  XLEN  read data

Behaviour:
- Reset: state IDLE; every output is 0; registered address, size and data are cleared.
- FSM states: IDLE, REQ, RSP, DONE.
- IDLE: a new access starts when lsu_req_i=1 and lsu_kill_i=0. At that edge the unit latches we, size, addr[1:0], word address, be and wdata.
  - Aligned access: next state is REQ.
  - Misaligned access: next state is DONE with the misaligned flag set, and no memory request is made.
- Misaligned conditions: H/HU with addr[0]=1; W with addr[1:0]!=0. B/BU is never misaligned.
- REQ: data_req_o=1, and addr/be/we/wdata are driven from the registers and held stable until grant.
  - data_gnt_i=1 moves the FSM to RSP and drops data_req_o the next cycle.
  - lsu_kill_i=1 before grant returns the FSM to IDLE with no completion. Kill and grant in the same cycle: grant wins.
- RSP: wait for data_rvalid_i, then go to DONE. rdata is captured only when the access is a load.
  - Kill in RSP is remembered. The response is still consumed, but lsu_valid_o is suppressed and the FSM returns directly to IDLE.
- DONE: lsu_valid_o=1 for exactly one cycle, then IDLE. lsu_req_i is ignored in DONE so the held instruction is not reissued.
- lsu_stall_req_o = lsu_req_i and state!=DONE. Its effect on a fresh request is combinational. The minimum stall is 3 cycles (IDLE, REQ, RSP) when grant and rvalid each arrive one cycle after request.
- Byte enables:
  - B: 0001<<addr[1:0]
  - H: 0011<<{addr[1],0}
  - W: 1111
  - size[1:0]=11 is treated as W. The decoder never issues these sizes.
- wdata: byte replicated x4; half replicated x2; word passed through.
- Load extract:
  - Byte: rdata[8*addr[1:0]+:8].
  - Half: rdata[16*addr[1]+:16].
  - Result is sign-extended when size[2]=0 and zero-extended when size[2]=1.
  - lsu_data_o is 0 for stores and misaligned accesses.
- Stray data_gnt_i or data_rvalid_i in IDLE or DONE is ignored.
- rst_i in any state forces IDLE and clears outputs on the next edge. A response arriving after reset is ignored.

Decomposition:
- Package miriscv_lsu_pkg holds:
  - lsu_state_e: IDLE, REQ, RSP, DONE.
  - Size constants MEM_B=3'b000, MEM_H=3'b001, MEM_W=3'b010, MEM_BU=3'b100, MEM_HU=3'b101.
- Sub-module miriscv_lsu_align is purely combinational. It takes size, addr[1:0], store data and read data, and produces be, wdata, misaligned and extended load data. The FSM and registers stay in miriscv_lsu.

Test Plan:
- LW at 0x100, memory returns 0xDEADBEEF, gnt and rvalid one cycle after request -> data_addr_o=0x100, be=1111; lsu_valid_o pulses 3 cycles after request with lsu_data_o=0xDEADBEEF; stall is high for exactly those 3 cycles.
- LB at 0x203, rdata=0x80xxxxxx -> be=1000, lsu_data_o=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x202 with rdata=0xBEEF0000 -> be=1100, 0x0000BEEF.
- SH at 0x306, data=0x1234ABCD -> data_we_o=1, be=1100, wdata=0xABCDABCD, addr=0x304; lsu_valid_o after rvalid; lsu_data_o=0.
- LW at 0x101 -> no data_req_o; lsu_valid_o=1 and lsu_misaligned_o=1 one cycle after request.
- Grant delayed 4 cycles -> data_req_o, data_addr_o and data_be_o stable throughout. Kill in REQ -> back to IDLE, no valid. Kill in RSP -> response consumed, no valid pulse.
- rst_i asserted while in RSP, then rvalid arrives -> all outputs 0, FSM in IDLE, and the late rvalid produces no valid pulse.

Source files
------------

// File: rtl/miriscv_lsu_pkg.sv
// Shared types and constants for the miriscv load/store unit.
package miriscv_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  // funct3 encodings of the memory access size
  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

endpackage

// File: rtl/miriscv_lsu_if.sv
// Data-memory port of the load/store unit: req/gnt request phase, rvalid response phase.
interface miriscv_lsu_if #(
  parameter int XLEN = 32
);

  logic            data_req;
  logic            data_we;
  logic [3:0]      data_be;
  logic [XLEN-1:0] data_addr;
  logic [XLEN-1:0] data_wdata;
  logic            data_gnt;
  logic            data_rvalid;
  logic [XLEN-1:0] data_rdata;

  modport master (
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_gnt, data_rvalid, data_rdata
  );

  modport slave (
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_gnt, data_rvalid, data_rdata
  );

endinterface

// File: rtl/miriscv_lsu_align.sv
// Byte-lane steering for the LSU: store byte enables and replication,
// misalignment detection, and load extraction with sign/zero extension.
module miriscv_lsu_align
  import miriscv_lsu_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned,
  output logic [31:0] load_data
);

  logic [31:0]        rdata_sh_b;
  logic [31:0]        rdata_sh_h;
  logic signed [7:0]  ld_byte;
  logic signed [15:0] ld_half;

  // Store side: lane enables, replicated write data and alignment check
  always_comb begin
    be         = 4'b0000;
    wdata      = '0;
    misaligned = 1'b0;
    case (size[1:0])
      2'b00: begin
        be    = 4'b0001 << offset;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be         = 4'b0011 << {offset[1], 1'b0};
        wdata      = {2{store_data[15:0]}};
        misaligned = offset[0];
      end
      default: begin
        // size[1:0]=11 is never issued by the decoder; it behaves as a word
        be         = 4'b1111;
        wdata      = store_data;
        misaligned = (offset != 2'b00);
      end
    endcase
  end

  // Load side: pick the addressed byte/half and extend it according to size[2]
  always_comb begin
    rdata_sh_b = rdata >> {offset, 3'b000};
    rdata_sh_h = rdata >> {offset[1], 4'b0000};
    ld_byte    = $signed(rdata_sh_b[7:0]);
    ld_half    = $signed(rdata_sh_h[15:0]);
    load_data  = rdata;
    case (size[1:0])
      2'b00:   load_data = size[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   load_data = size[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/miriscv_lsu.sv
// Load/store unit: runs one req/gnt/rvalid memory transaction per memory
// instruction, stalls the pipeline until it finishes, and returns the
// extended load result with a one-cycle completion pulse.
module miriscv_lsu
  import miriscv_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            lsu_req_i,
  input  logic            lsu_we_i,
  input  logic [2:0]      lsu_size_i,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic [XLEN-1:0] lsu_data_i,
  input  logic            lsu_kill_i,
  output logic            lsu_stall_req_o,
  output logic            lsu_valid_o,
  output logic            lsu_misaligned_o,
  output logic [XLEN-1:0] lsu_data_o,
  miriscv_lsu_if.master   mem
);

  lsu_state_e      state_q, state_d;

  logic            we_q;
  logic [2:0]      size_q;
  logic [1:0]      offset_q;
  logic [XLEN-1:0] addr_q;
  logic [3:0]      be_q;
  logic [XLEN-1:0] wdata_q;
  logic            mis_q;
  logic [XLEN-1:0] data_q;
  logic            kill_q;

  logic            start;
  logic [2:0]      al_size;
  logic [1:0]      al_offset;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata;
  logic            al_mis;
  logic [XLEN-1:0] al_load;

  // In IDLE the aligner sees the live request; afterwards the latched access,
  // so the same lane logic serves both the request and the response.
  assign al_size   = (state_q == IDLE) ? lsu_size_i      : size_q;
  assign al_offset = (state_q == IDLE) ? lsu_addr_i[1:0] : offset_q;
  assign start     = (state_q == IDLE) && lsu_req_i && !lsu_kill_i;

  miriscv_lsu_align u_align (
    .size       (al_size),
    .offset     (al_offset),
    .store_data (lsu_data_i),
    .rdata      (mem.data_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .misaligned (al_mis),
    .load_data  (al_load)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; grant takes priority over kill in REQ
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = al_mis ? DONE : REQ;
        end
      end
      REQ: begin
        if (mem.data_gnt) begin
          state_d = RSP;
        end else if (lsu_kill_i) begin
          state_d = IDLE;
        end
      end
      RSP: begin
        if (mem.data_rvalid) begin
          state_d = (kill_q || lsu_kill_i) ? IDLE : DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Access registers: latched at start, load result captured on the response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q     <= 1'b0;
      size_q   <= '0;
      offset_q <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      mis_q    <= 1'b0;
      data_q   <= '0;
      kill_q   <= 1'b0;
    end else begin
      if (start) begin
        we_q     <= lsu_we_i;
        size_q   <= lsu_size_i;
        offset_q <= lsu_addr_i[1:0];
        addr_q   <= {lsu_addr_i[XLEN-1:2], 2'b00};
        be_q     <= al_be;
        wdata_q  <= al_wdata;
        mis_q    <= al_mis;
        data_q   <= '0;
        kill_q   <= 1'b0;
      end
      if ((state_q == RSP) && lsu_kill_i) begin
        kill_q <= 1'b1;
      end
      if ((state_q == RSP) && mem.data_rvalid && !we_q) begin
        data_q <= al_load;
      end
    end
  end

  assign lsu_stall_req_o  = lsu_req_i && (state_q != DONE);
  assign lsu_valid_o      = (state_q == DONE);
  assign lsu_misaligned_o = (state_q == DONE) && mis_q;
  assign lsu_data_o       = (state_q == DONE) ? data_q : '0;

  assign mem.data_req   = (state_q == REQ);
  assign mem.data_we    = (state_q == REQ) && we_q;
  assign mem.data_be    = (state_q == REQ) ? be_q    : 4'b0000;
  assign mem.data_addr  = (state_q == REQ) ? addr_q  : '0;
  assign mem.data_wdata = (state_q == REQ) ? wdata_q : '0;

endmodule

// File: tb/tb_miriscv_lsu.sv
// Directed bench for miriscv_lsu: vector table for single accesses plus
// hand-written kill, reset and delayed-grant sequences.
module tb_miriscv_lsu;
  import miriscv_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req, lsu_we, lsu_kill;
  logic [2:0]  lsu_size;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_stall_req_o, lsu_valid_o, lsu_misaligned_o;
  logic [31:0] lsu_data_o;

  miriscv_lsu_if #(.XLEN(32)) bus ();

  miriscv_lsu #(.XLEN(32)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .lsu_req_i        (lsu_req),
    .lsu_we_i         (lsu_we),
    .lsu_size_i       (lsu_size),
    .lsu_addr_i       (lsu_addr),
    .lsu_data_i       (lsu_wdata),
    .lsu_kill_i       (lsu_kill),
    .lsu_stall_req_o  (lsu_stall_req_o),
    .lsu_valid_o      (lsu_valid_o),
    .lsu_misaligned_o (lsu_misaligned_o),
    .lsu_data_o       (lsu_data_o),
    .mem              (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  vec_t vecs [16];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic we, input logic [2:0] sz, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input logic [3:0] be,
                              input logic [31:0] ea, input logic [31:0] ewd,
                              input logic [31:0] ed, input logic em);
    vec_t v;
    v.we = we; v.size = sz; v.addr = a; v.wdata = wd; v.rdata = rd;
    v.exp_be = be; v.exp_addr = ea; v.exp_wdata = ewd; v.exp_data = ed; v.exp_mis = em;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_data_req"},   {31'b0, bus.data_req}, 32'd0);
    chk({tag, "_data_we"},    {31'b0, bus.data_we}, 32'd0);
    chk({tag, "_data_be"},    {28'b0, bus.data_be}, 32'd0);
    chk({tag, "_data_addr"},  bus.data_addr, 32'd0);
    chk({tag, "_data_wdata"}, bus.data_wdata, 32'd0);
    chk({tag, "_valid"},      {31'b0, lsu_valid_o}, 32'd0);
    chk({tag, "_mis"},        {31'b0, lsu_misaligned_o}, 32'd0);
    chk({tag, "_data"},       lsu_data_o, 32'd0);
    chk({tag, "_stall"},      {31'b0, lsu_stall_req_o}, 32'd0);
  endtask

  // One full access starting at a negedge; grant after gnt_delay REQ cycles, rvalid one cycle later
  task automatic run_vec(input vec_t v, input int idx, input int gnt_delay);
    int stall_cnt;
    stall_cnt = 0;
    lsu_req = 1'b1; lsu_we = v.we; lsu_size = v.size; lsu_addr = v.addr; lsu_wdata = v.wdata;
    #1;
    chk($sformatf("v%0d_stall_start", idx), {31'b0, lsu_stall_req_o}, 32'd1);
    if (lsu_stall_req_o) stall_cnt++;
    @(negedge clk);
    if (v.exp_mis) begin
      chk($sformatf("v%0d_mis_no_req", idx), {31'b0, bus.data_req}, 32'd0);
      chk($sformatf("v%0d_mis_valid", idx), {31'b0, lsu_valid_o}, 32'd1);
      chk($sformatf("v%0d_mis_flag", idx), {31'b0, lsu_misaligned_o}, 32'd1);
      chk($sformatf("v%0d_mis_data", idx), lsu_data_o, 32'd0);
      chk($sformatf("v%0d_mis_stall", idx), {31'b0, lsu_stall_req_o}, 32'd0);
    end else begin
      for (int i = 1; i <= gnt_delay; i++) begin
        chk($sformatf("v%0d_req_c%0d", idx, i), {31'b0, bus.data_req}, 32'd1);
        chk($sformatf("v%0d_addr_c%0d", idx, i), bus.data_addr, v.exp_addr);
        chk($sformatf("v%0d_be_c%0d", idx, i), {28'b0, bus.data_be}, {28'b0, v.exp_be});
        chk($sformatf("v%0d_we_c%0d", idx, i), {31'b0, bus.data_we}, {31'b0, v.we});
        if (v.we) chk($sformatf("v%0d_wdata_c%0d", idx, i), bus.data_wdata, v.exp_wdata);
        if (lsu_stall_req_o) stall_cnt++;
        if (i == gnt_delay) bus.data_gnt = 1'b1;
        @(negedge clk);
        bus.data_gnt = 1'b0;
      end
      chk($sformatf("v%0d_rsp_req_low", idx), {31'b0, bus.data_req}, 32'd0);
      chk($sformatf("v%0d_rsp_no_valid", idx), {31'b0, lsu_valid_o}, 32'd0);
      if (lsu_stall_req_o) stall_cnt++;
      bus.data_rvalid = 1'b1;
      bus.data_rdata  = v.rdata;
      @(negedge clk);
      bus.data_rvalid = 1'b0;
      bus.data_rdata  = 32'h5A5A_5A5A;
      chk($sformatf("v%0d_valid", idx), {31'b0, lsu_valid_o}, 32'd1);
      chk($sformatf("v%0d_data", idx), lsu_data_o, v.exp_data);
      chk($sformatf("v%0d_mis_low", idx), {31'b0, lsu_misaligned_o}, 32'd0);
      chk($sformatf("v%0d_done_stall", idx), {31'b0, lsu_stall_req_o}, 32'd0);
      chk($sformatf("v%0d_stall_cycles", idx), stall_cnt, gnt_delay + 2);
    end
    lsu_req = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_valid_one_shot", idx), {31'b0, lsu_valid_o}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; lsu_req = 1'b0; lsu_we = 1'b0; lsu_kill = 1'b0;
    lsu_size = MEM_W; lsu_addr = '0; lsu_wdata = '0;
    bus.data_gnt = 1'b0; bus.data_rvalid = 1'b0; bus.data_rdata = '0;

    vecs[0]  = mk(0, MEM_W,  32'h100, 32'h0,        32'hDEADBEEF, 4'b1111, 32'h100, 32'h0,        32'hDEADBEEF, 0);
    vecs[1]  = mk(0, MEM_B,  32'h203, 32'h0,        32'h80123456, 4'b1000, 32'h200, 32'h0,        32'hFFFFFF80, 0);
    vecs[2]  = mk(0, MEM_BU, 32'h203, 32'h0,        32'h80123456, 4'b1000, 32'h200, 32'h0,        32'h00000080, 0);
    vecs[3]  = mk(0, MEM_HU, 32'h202, 32'h0,        32'hBEEF0000, 4'b1100, 32'h200, 32'h0,        32'h0000BEEF, 0);
    vecs[4]  = mk(1, MEM_H,  32'h306, 32'h1234ABCD, 32'hFFFFFFFF, 4'b1100, 32'h304, 32'hABCDABCD, 32'h0,        0);
    vecs[5]  = mk(0, MEM_W,  32'h101, 32'h0,        32'h0,        4'b0000, 32'h0,   32'h0,        32'h0,        1);
    vecs[6]  = mk(0, MEM_H,  32'h202, 32'h0,        32'h80010000, 4'b1100, 32'h200, 32'h0,        32'hFFFF8001, 0);
    vecs[7]  = mk(0, MEM_B,  32'h201, 32'h0,        32'h0000A500, 4'b0010, 32'h200, 32'h0,        32'hFFFFFFA5, 0);
    vecs[8]  = mk(1, MEM_B,  32'h102, 32'h000000A7, 32'hFFFFFFFF, 4'b0100, 32'h100, 32'hA7A7A7A7, 32'h0,        0);
    vecs[9]  = mk(1, MEM_W,  32'h10C, 32'hCAFEF00D, 32'hFFFFFFFF, 4'b1111, 32'h10C, 32'hCAFEF00D, 32'h0,        0);
    vecs[10] = mk(0, MEM_H,  32'h203, 32'h0,        32'h0,        4'b0000, 32'h0,   32'h0,        32'h0,        1);
    vecs[11] = mk(0, MEM_HU, 32'h101, 32'h0,        32'h0,        4'b0000, 32'h0,   32'h0,        32'h0,        1);
    vecs[12] = mk(1, MEM_W,  32'h102, 32'hCAFEF00D, 32'h0,        4'b0000, 32'h0,   32'h0,        32'h0,        1);
    vecs[13] = mk(0, MEM_BU, 32'h003, 32'h0,        32'hFF000000, 4'b1000, 32'h000, 32'h0,        32'h000000FF, 0);
    vecs[14] = mk(0, MEM_HU, 32'h200, 32'h0,        32'h1234F00D, 4'b0011, 32'h200, 32'h0,        32'h0000F00D, 0);
    vecs[15] = mk(0, MEM_B,  32'h200, 32'h0,        32'hFFFFFF12, 4'b0001, 32'h200, 32'h0,        32'h00000012, 0);

    // Reset state
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Stray grant/response while idle
    bus.data_gnt = 1'b1; bus.data_rvalid = 1'b1; bus.data_rdata = 32'h12345678;
    @(negedge clk);
    bus.data_gnt = 1'b0; bus.data_rvalid = 1'b0;
    chk("stray_no_req", {31'b0, bus.data_req}, 32'd0);
    chk("stray_no_valid", {31'b0, lsu_valid_o}, 32'd0);

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i, 1);

    // Grant held off for four REQ cycles; bus must stay stable throughout
    run_vec(mk(0, MEM_W, 32'h400, 32'h0, 32'h0BADF00D, 4'b1111, 32'h400, 32'h0, 32'h0BADF00D, 0), 20, 4);

    // Kill in IDLE blocks the start
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = MEM_W; lsu_addr = 32'h480; lsu_kill = 1'b1;
    @(negedge clk);
    lsu_req = 1'b0; lsu_kill = 1'b0;
    chk("kill_idle_no_req", {31'b0, bus.data_req}, 32'd0);

    // Kill in REQ before grant returns to IDLE with no completion
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = MEM_W; lsu_addr = 32'h500;
    @(negedge clk);
    chk("kill_req_in_req", {31'b0, bus.data_req}, 32'd1);
    lsu_kill = 1'b1;
    @(negedge clk);
    lsu_kill = 1'b0; lsu_req = 1'b0;
    chk("kill_req_dropped", {31'b0, bus.data_req}, 32'd0);
    chk("kill_req_no_valid", {31'b0, lsu_valid_o}, 32'd0);
    @(negedge clk);
    chk("kill_req_no_valid2", {31'b0, lsu_valid_o}, 32'd0);

    // Kill in RSP: response consumed, no valid pulse
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = MEM_W; lsu_addr = 32'h600;
    @(negedge clk);
    bus.data_gnt = 1'b1;
    @(negedge clk);
    bus.data_gnt = 1'b0;
    lsu_kill = 1'b1; lsu_req = 1'b0;
    @(negedge clk);
    lsu_kill = 1'b0;
    chk("kill_rsp_no_req", {31'b0, bus.data_req}, 32'd0);
    chk("kill_rsp_wait", {31'b0, lsu_valid_o}, 32'd0);
    bus.data_rvalid = 1'b1; bus.data_rdata = 32'h11111111;
    @(negedge clk);
    bus.data_rvalid = 1'b0;
    chk("kill_rsp_no_valid", {31'b0, lsu_valid_o}, 32'd0);
    chk("kill_rsp_no_data", lsu_data_o, 32'd0);
    @(negedge clk);
    chk("kill_rsp_no_valid2", {31'b0, lsu_valid_o}, 32'd0);
    run_vec(mk(0, MEM_W, 32'h700, 32'h0, 32'h76543210, 4'b1111, 32'h700, 32'h0, 32'h76543210, 0), 21, 1);

    // Reset while waiting for the response; the late rvalid is ignored
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_size = MEM_W; lsu_addr = 32'h800; lsu_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    bus.data_gnt = 1'b1;
    @(negedge clk);
    bus.data_gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; lsu_req = 1'b0;
    #1;
    chk_idle_outputs("rst_rsp");
    bus.data_rvalid = 1'b1; bus.data_rdata = 32'h22222222;
    @(negedge clk);
    bus.data_rvalid = 1'b0;
    chk("rst_late_rvalid_no_valid", {31'b0, lsu_valid_o}, 32'd0);
    @(negedge clk);
    chk("rst_late_rvalid_no_valid2", {31'b0, lsu_valid_o}, 32'd0);
    chk("rst_late_rvalid_no_req", {31'b0, bus.data_req}, 32'd0);
    run_vec(mk(0, MEM_B, 32'h901, 32'h0, 32'h00007F00, 4'b0010, 32'h900, 32'h0, 32'h0000007F, 0), 22, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
